// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO widths and Gray-code helpers
package fifo_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int GRAY_MAX_W = 32;

    // Operands are zero-extended, so these serve any pointer width up to GRAY_MAX_W.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// rtl/fifo_sync2.sv - two-flop synchronizer for Gray pointers crossing clock domains
module fifo_sync2 #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side controller with 2-entry output buffer
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty
);
    import fifo_pkg::*;

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_sync_gray;
    logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic                  head_q, head_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  rd_empty_q, rd_empty_d;
    logic                  mem_empty;
    logic                  pop;
    logic                  push;
    logic                  fetch;
    logic                  tail;
    logic [2:0]            occupancy;

    fifo_sync2 #(
        .WIDTH (PW)
    ) u_wr_sync (
        .clk_i (rd_clk),
        .rst_i (rd_rst),
        .d_i   (wr_ptr_gray),
        .q_o   (wr_sync_gray)
    );

    always_comb begin
        mem_empty = (rd_ptr_gray_q == wr_sync_gray);
        pop       = (buf_cnt_q != 2'd0) && rd_ready;
        push      = inflight_q;
        // Words already buffered or in flight, minus the one leaving this edge.
        occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        fetch     = !mem_empty && (occupancy < 3'd2);

        rd_ptr_bin_d  = rd_ptr_bin_q + PW'(fetch);
        rd_ptr_gray_d = PW'(bin2gray(GRAY_MAX_W'(rd_ptr_bin_d)));
        inflight_d    = fetch;
        head_d        = head_q ^ pop;
        buf_cnt_d     = buf_cnt_q + {1'b0, push} - {1'b0, pop};
        tail          = head_q ^ buf_cnt_q[0];
        rd_empty_d    = (rd_ptr_gray_d == wr_sync_gray) && !inflight_d && (buf_cnt_d == 2'd0);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            inflight_q    <= 1'b0;
            head_q        <= 1'b0;
            buf_cnt_q     <= 2'd0;
            obuf_q[0]     <= '0;
            obuf_q[1]     <= '0;
            rd_empty_q    <= 1'b1;
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            inflight_q    <= inflight_d;
            head_q        <= head_d;
            buf_cnt_q     <= buf_cnt_d;
            rd_empty_q    <= rd_empty_d;
            if (push) begin
                obuf_q[tail] <= mem_rd_data;
            end
        end
    end

    assign rd_ptr_gray = rd_ptr_gray_q;
    assign rd_addr     = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign rd_valid    = (buf_cnt_q != 2'd0);
    assign rd_data     = obuf_q[head_q];
    assign rd_empty    = rd_empty_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rd_rst;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
    logic [3:0] rd_addr;
    logic [7:0] mem_rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_empty;

    fifo_rd_ctrl #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .rd_clk      (clk),
        .rd_rst      (rd_rst),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .rd_addr     (rd_addr),
        .mem_rd_data (mem_rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_empty    (rd_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) mem_rd_data <= mem[rd_addr];

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q [$];
    logic [4:0] wbin;
    logic [4:0] popped;
    int         pops_total;
    logic       have_prev;
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_data;
    logic [4:0] prev_gray;

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 5'd1;
        wr_ptr_gray = b2g(wbin);
    endtask

    // Check invariants at the current negedge, account for the pop at the next edge, advance a cycle.
    task automatic tick();
        logic [4:0] ahead;
        if (!rd_rst) begin
            if (have_prev && prev_valid && !prev_ready) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, prev_data);
            end
            if (have_prev) chk("gray_1bit", ($countones(rd_ptr_gray ^ prev_gray) <= 1), 1);
            ahead = g2b(rd_ptr_gray) - popped;
            chk("ahead_le2", (ahead <= 5'd2), 1);
            chk("ahead_le_avail", (ahead <= 5'(wbin - popped)), 1);
            if (rd_empty) chk("empty_novalid", rd_valid, 0);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 1, 0);
                end else begin
                    chk("data_order", rd_data, exp_q.pop_front());
                    popped = popped + 5'd1;
                    pops_total++;
                end
            end
        end
        have_prev  = !rd_rst;
        prev_valid = rd_valid;
        prev_ready = rd_ready;
        prev_data  = rd_data;
        prev_gray  = rd_ptr_gray;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        rd_ready = 1'b0;
        wbin = 5'd0;
        wr_ptr_gray = 5'd0;
        exp_q.delete();
        popped = 5'd0;
        pops_total = 0;
        tick();
        tick();
        rd_rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        rd_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk({tag, "_left"}, exp_q.size(), 0);
        tick();
        tick();
        chk({tag, "_empty"}, rd_empty, 1);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_gray"}, rd_ptr_gray, b2g(wbin));
    endtask

    initial begin
        logic       wrapped;
        logic [4:0] prev_rbin;
        logic [4:0] cur_rbin;
        int         sent;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        have_prev = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data = 8'h00;
        prev_gray = 5'd0;
        popped = 5'd0;
        pops_total = 0;
        wbin = 5'd0;
        wr_ptr_gray = 5'd0;
        rd_ready = 1'b0;
        rd_rst = 1'b1;

        // Reset with two words already advertised by the write side.
        write_word(8'h3C);
        write_word(8'h5A);
        chk("rst_wptr_setup", wr_ptr_gray, 5'b00011);
        tick();
        tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_addr", rd_addr, 0);
        chk("rst_gray", rd_ptr_gray, 0);
        rd_rst = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_lat_e2_valid", rd_valid, 0);
        tick();
        chk("rst_lat_e3_valid", rd_valid, 1);
        chk("rst_lat_e3_data", rd_data, 8'h3C);
        drain("rst");

        // Single word latency.
        do_reset();
        rd_ready = 1'b1;
        write_word(8'hA5);
        tick();
        tick();
        chk("single_e1_gray", rd_ptr_gray, 5'b00000);
        tick();
        chk("single_e2_gray", rd_ptr_gray, 5'b00001);
        chk("single_e2_valid", rd_valid, 0);
        tick();
        chk("single_e3_valid", rd_valid, 1);
        chk("single_e3_data", rd_data, 8'hA5);
        tick();
        chk("single_e4_valid", rd_valid, 0);
        chk("single_e4_empty", rd_empty, 1);

        // Full memory streamed back to back.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'(i));
        chk("stream_wptr", wr_ptr_gray, 5'b11000);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", rd_valid, 1);
            tick();
        end
        chk("stream_end_valid", rd_valid, 0);
        chk("stream_end_gray", rd_ptr_gray, 5'b11000);
        chk("stream_count", pops_total, 16);

        // Backpressure: at most two words fetched ahead.
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'h40 + 8'(i));
        for (int i = 0; i < 10; i++) tick();
        chk("bp_rptr", g2b(rd_ptr_gray), 2);
        chk("bp_valid", rd_valid, 1);
        chk("bp_data", rd_data, 8'h40);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_release_valid", rd_valid, 1);
            tick();
        end
        chk("bp_end_valid", rd_valid, 0);
        chk("bp_count", pops_total, 5);

        // Bursty writes, random ready, pointer wrap.
        do_reset();
        sent = 0;
        wrapped = 1'b0;
        prev_rbin = 5'd0;
        for (int cyc = 0; cyc < 3000 && (sent < 40 || exp_q.size() != 0); cyc++) begin
            if (sent < 40 && ($urandom % 4) != 0 && (5'(wbin - g2b(rd_ptr_gray)) < 5'd16)) begin
                write_word(8'($urandom));
                sent++;
            end
            rd_ready = 1'($urandom % 2);
            tick();
            cur_rbin = g2b(rd_ptr_gray);
            if (prev_rbin == 5'd31 && cur_rbin == 5'd0) wrapped = 1'b1;
            prev_rbin = cur_rbin;
        end
        chk("wrap_sent", sent, 40);
        chk("wrap_received", pops_total, 40);
        chk("wrap_seen", wrapped, 1);
        drain("wrap");

        // Reset with two words buffered discards them.
        do_reset();
        for (int i = 0; i < 6; i++) write_word(8'h90 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_pre_valid", rd_valid, 1);
        rd_rst = 1'b1;
        wbin = 5'd0;
        wr_ptr_gray = 5'd0;
        exp_q.delete();
        popped = 5'd0;
        tick();
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_gray", rd_ptr_gray, 0);
        rd_rst = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("midrst_no_stale", rd_valid, 0);
            tick();
        end
        chk("midrst_empty", rd_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain. It synchronizes the write pointer and detects empty. It drives the read address of `fifo_mem` (which has a one-cycle registered read) and presents words to the consumer over a valid/ready interface through a 2-entry output buffer, sustaining one word per cycle. It returns its Gray-coded read pointer to the write domain for full detection.

## Interface

Parameters:
- `ADDR_WIDTH`, default `fifo_pkg::ADDR_WIDTH`: memory address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, default `fifo_pkg::DATA_WIDTH`: word width.

Ports:
- `rd_clk`, input, 1: read-domain clock; the only clock of the block.
- `rd_rst`, input, 1: synchronous, active-high reset.
- `wr_ptr_gray`, input, ADDR_WIDTH+1: Gray write pointer from the write domain; asynchronous to `rd_clk`.
- `rd_ptr_gray`, output, ADDR_WIDTH+1: registered Gray read pointer, sent to the write domain.
- `rd_addr`, output, ADDR_WIDTH: to `fifo_mem`; equals `rd_ptr_bin[ADDR_WIDTH-1:0]`.
- `mem_rd_data`, input, DATA_WIDTH: `fifo_mem` read data; valid one cycle after `rd_addr`.
- `rd_valid`, output, 1: `rd_data` holds a word.
- `rd_ready`, input, 1: consumer accepts the word.
- `rd_data`, output, DATA_WIDTH: head word of the output buffer.
- `rd_empty`, output, 1: registered; high when no word is in memory, in flight, or buffered.

## Operation

**Write-pointer synchronizer**
- `wr_ptr_gray` passes through a 2-flop synchronizer to give `wr_sync_gray`.
- `wr_sync_bin = gray2bin(wr_sync_gray)`.

**Memory-empty flag**
- `mem_empty = (rd_ptr_gray == wr_sync_gray)`.
- This compare is combinational from registers.

**Fetch rule**
- `fetch = !mem_empty && (buf_cnt + inflight - pop) < 2`, where `pop = rd_valid && rd_ready`.
- On `fetch`, `rd_ptr_bin` increments, wrapping modulo 2^(ADDR_WIDTH+1).
- On the same edge, `rd_ptr_gray <= bin2gray(rd_ptr_bin + 1)`.
- On the same edge, `inflight <= 1`; otherwise `inflight <= 0`.

**Capture**
- When `inflight` is 1, `mem_rd_data` is written into the output buffer at the tail.
- The buffer is a 2-entry FIFO: head, tail and a 0..2 count.

**Pop**
- On `pop` the head advances.
- Push and pop on the same edge leave the count unchanged.
- Order is strictly preserved.

**Outputs**
- `rd_valid = (buf_cnt != 0)`.
- `rd_data` = head entry, stable while `rd_valid && !rd_ready`.
- `rd_empty` is registered: `rd_empty <= mem_empty_next && inflight_next == 0 && buf_cnt_next == 0`.

**Slot reuse**
- The write side may overwrite a slot once `rd_ptr_gray` has advanced past it.
- This is safe because the memory samples the slot on the same edge the pointer moves.

**Reset**
- Reset values on the edge where `rd_rst` is sampled high:
  - `rd_ptr_bin` and `rd_ptr_gray` = 0;
  - synchronizer flops = 0;
  - `inflight` = 0, buffer count = 0;
  - `rd_valid` = 0, `rd_data` = 0, `rd_empty` = 1, `rd_addr` = 0.
- Reset mid-stream discards buffered and in-flight words.
- The write side must be reset in the same system reset sequence.

**Boundary rules**
- Full memory (pointers differ only in the MSB) is not empty; fetches proceed normally.
- Pointer wrap 2^(ADDR_WIDTH+1)-1 → 0 is seamless.
- `rd_ready` high while `rd_valid` is low has no effect.

## Timing

**Latency: write pointer change to `rd_valid`**
- `wr_ptr_gray` stable before edge 0.
- Edge 0: sync stage 1.
- Edge 1: sync stage 2; `fetch` asserts in the following cycle.
- Edge 2: pointer increments and memory registers the data.
- Edge 3: buffer captures; `rd_valid` is high after edge 3.
- Total: 4 edges, minimum.

**Throughput**
- With `rd_ready` held high, throughput is 1 word per cycle.

**Backpressure**
- With `rd_ready` low, at most 2 words are fetched ahead.
- `rd_ptr` stops advancing after that.

**Pointer update**
- `rd_ptr_gray` changes at most one bit per edge; it is glitch-free for CDC.

## Structure

**`fifo_pkg` contents**
- `ADDR_WIDTH`, `DATA_WIDTH` (existing).
- Functions `bin2gray` and `gray2bin`, parameterized by width.
- These are shared with the write-side controller.

**Sub-module `fifo_sync2`**
- Parameterized-width 2-flop synchronizer with synchronous active-high reset.
- Reused by the write side for `rd_ptr_gray`.

**Expected size**
- Pointer logic, fetch control and the 2-entry output buffer fit in one module of about 150 lines.

## Test plan

All scenarios use `ADDR_WIDTH`=4, `DATA_WIDTH`=8, with `fifo_mem` attached.

1. **Reset:** `rd_rst` high 2 cycles with `wr_ptr_gray`=5'b00011 → `rd_valid`=0, `rd_empty`=1, `rd_addr`=0, `rd_ptr_gray`=0. After release, the first word appears 4 edges later.
2. **Single word:** preload mem[0]=0xA5; `wr_ptr_gray` 0→5'b00001 before edge 0, `rd_ready`=1 → `rd_ptr_gray`=5'b00001 after edge 2; `rd_valid`=1 and `rd_data`=0xA5 after edge 3. After edge 4: `rd_valid`=0, `rd_empty`=1.
3. **Streaming full memory:** 16 words 0x00..0x0F, `wr_ptr_gray`=5'b11000 (bin 16), `rd_ready`=1 → after 4-edge latency, 16 consecutive cycles of valid data in order. Final `rd_ptr_gray`=5'b11000.
4. **Backpressure:** 5 words available, `rd_ready`=0 → `rd_ptr_bin` stops at 2; `rd_data`=word0 held stable. Then `rd_ready`=1 → words 0..4 in order, one per cycle.
5. **Wrap and random ready:** 40 words written in bursts, `rd_ready` random 50% → every word received exactly once in order. `rd_ptr_bin` wraps 31→0 with one Gray bit change per edge.
6. **Reset mid-stream:** `rd_rst` asserted with 2 words buffered → `rd_valid`=0 and `rd_ptr_gray`=0 on the next edge; no stale word appears after release.
